block_packer: RTL
=================

# block_packer

Re-packs the compacted, variable-occupancy beats produced by the 8-lane block-shift tree (up to NUM_BLOCKS valid blocks packed at the LSB end, count on `in_num`) into dense output words of exactly NUM_BLOCKS blocks. A final partial word is emitted when a frame ends on `in_last`. It sits directly downstream of the block-shift tree and upstream of the memory/stream writer, which needs full-width beats.

## Interface
- BLOCK_SIZE, 128, bits per block
- NUM_BLOCKS, 8, blocks per input and output word (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_ready  out  1  can accept an input beat
- in_data  in  NUM_BLOCKS*BLOCK_SIZE  packed blocks; block k at [k*BLOCK_SIZE +: BLOCK_SIZE]
- in_valid  in  1  input beat valid
- in_num  in  32  valid blocks in beat, 0..NUM_BLOCKS; blocks 0..in_num-1 valid
- in_last  in  1  beat ends the frame
- ready_4_output  in  1  downstream accepts output
- out_data  out  NUM_BLOCKS*BLOCK_SIZE  packed output; unused blocks zero
- out_valid  out  1  output beat valid
- out_num  out  32  valid blocks in output beat
- out_last  out  1  final beat of frame

## Operation
- Buffer: 2*NUM_BLOCKS block registers plus `fill` count (0..2*NUM_BLOCKS). The oldest block is at index 0.
- Accept: `in_valid && in_ready`. Blocks 0..in_num-1 are written at buffer index `fill - pop_cnt` onward, so order is preserved.
- Pop: `out_valid && ready_4_output`. Pops `out_num` blocks, and the buffer shifts down by `out_num`.
- Next fill: `fill - pop_cnt + acc_cnt`.
- State FILL (`flush=0`):
  - `in_ready = (fill <= NUM_BLOCKS)`.
  - `out_valid = (fill >= NUM_BLOCKS)`.
  - `out_num = NUM_BLOCKS`, `out_last = 0`.
  - Accepting a beat with `in_last=1` moves the block to DRAIN.
- State DRAIN (`flush=1`):
  - `in_ready = 0`, `out_valid = 1`.
  - `out_num = min(fill, NUM_BLOCKS)`.
  - `out_last = (fill <= NUM_BLOCKS)`.
  - Popping the `out_last` beat returns the block to FILL with `fill=0`.
- Empty frame: `in_last` with `in_num=0` and `fill=0` produces one beat with `out_num=0`, `out_last=1` and all-zero `out_data`.
- `in_num` above NUM_BLOCKS is illegal. RTL behaviour is undefined; the bench never drives it.
- `in_data` blocks at index ≥ `in_num` are ignored.
- Output blocks at index ≥ `out_num` are zero.
- Simultaneous accept and pop in FILL is legal and required for full throughput.

## Timing
- Reset state: fill=0, flush=0, buffer zero. While rst is high, all outputs are 0, including `in_ready`. `in_ready` is 1 in the first cycle after rst deasserts.
- All outputs decode combinationally from registers only. There is no input-to-output combinational path, and `in_ready` does not depend on `ready_4_output`.
- Latency: a block accepted in cycle t is visible on `out_data` in cycle t+1 at the earliest.
- Throughput: continuous `in_num=NUM_BLOCKS` with `ready_4_output=1` gives one full output beat per cycle after the first beat.
- Handshake hold: while `out_valid && !ready_4_output`, `out_data`, `out_num` and `out_last` stay stable. An input accepted in FILL lands only at index ≥ NUM_BLOCKS, so the held output beat is unchanged.
- Reset mid-frame: buffered blocks and the pending flush are discarded. No `out_last` is emitted.

## Configuration
- Macro: `BLOCK_PACKER_STATS_EN`.
- When defined:
  - Adds output port `out_total` (32 bits): blocks of the current frame popped so far, including the current beat.
  - The counter clears on the pop of the `out_last` beat and on rst.
- When undefined: the port and counter are absent and the remaining behaviour is identical.

## Structure
- Package `block_pkg`:
  - default BLOCK_SIZE and NUM_BLOCKS constants;
  - `CNT_W = $clog2(2*NUM_BLOCKS)+1`;
  - state enum `{FILL, DRAIN}`.
- Sub-module `block_insert_shift`: combinational. It shifts the buffer down by `pop_cnt` and places the input blocks at offset `fill - pop_cnt`. It is instantiated once.

## Test plan
- **Full beats:** NUM_BLOCKS=8, five beats with `in_num=8` back-to-back, `ready_4_output=1`.
  - Expect five outputs with `out_num=8` on consecutive cycles, blocks in order, first output in the cycle after the first accept.
- **Partial merge:** beats with `in_num` 3, 3, 3, then 7 with `in_last`.
  - Expect outputs: 8 blocks (`out_last=0`), then 8 (`out_last=0`), then 0 further, then a final beat of 0 blocks? No: 16 blocks total gives two beats of 8, and the second has `out_last=1`.
  - Check exact block order across beats.
- **Odd tail:** `in_num` 5 then 6 with `in_last`.
  - Expect an `out_num=8` beat, then an `out_num=3` beat with `out_last=1` and blocks 3..7 zero. `in_ready` is 0 until the final pop.
- **Backpressure:** hold `ready_4_output=0` for 10 cycles with `fill=8`, then offer a beat with `in_num=4`.
  - It is accepted and `out_data` is unchanged during the stall.
  - A second beat is refused, since fill=12 gives `in_ready=0`.
- **Empty frame:** `in_last` with `in_num=0` on an empty buffer.
  - Expect exactly one beat with `out_num=0`, `out_last=1`, `out_data=0`.
- **Reset mid-frame:** `fill=5` in DRAIN, assert rst for one cycle.
  - Expect all outputs 0 in that cycle, `in_ready=1` next cycle and no stale output.

Source files
------------

// File: rtl/block_pkg.sv
// Shared constants, counter-width helper and FSM state type for the block packer.
package block_pkg;

    localparam int unsigned DEF_BLOCK_SIZE = 128;
    localparam int unsigned DEF_NUM_BLOCKS = 8;

    // Wide enough to hold 0..2*n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(2 * n) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_w(DEF_NUM_BLOCKS);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/block_insert_shift.sv
// Combinational buffer update: drop pop_cnt oldest blocks, then append acc_cnt input blocks.
module block_insert_shift
    import block_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int unsigned CW         = cnt_w(NUM_BLOCKS)
) (
    input  logic [2*NUM_BLOCKS*BLOCK_SIZE-1:0] blocks,
    input  logic [CW-1:0]                      fill,
    input  logic [CW-1:0]                      pop_cnt,
    input  logic [CW-1:0]                      acc_cnt,
    input  logic [NUM_BLOCKS*BLOCK_SIZE-1:0]   in_data,
    output logic [2*NUM_BLOCKS*BLOCK_SIZE-1:0] blocks_next
);

    localparam int unsigned DEPTH = 2 * NUM_BLOCKS;

    logic [CW-1:0] keep;

    assign keep = fill - pop_cnt;

    // Slots below keep take surviving blocks; the next acc_cnt slots take new input; the rest stay zero.
    always_comb begin
        blocks_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((CW'(i) < keep) && (CW'(j) == CW'(i) + pop_cnt)) begin
                    blocks_next[i*BLOCK_SIZE +: BLOCK_SIZE] = blocks[j*BLOCK_SIZE +: BLOCK_SIZE];
                end
            end
            for (int j = 0; j < NUM_BLOCKS; j++) begin
                if ((CW'(i) >= keep) && (CW'(j) == CW'(i) - keep) && (CW'(j) < acc_cnt)) begin
                    blocks_next[i*BLOCK_SIZE +: BLOCK_SIZE] = in_data[j*BLOCK_SIZE +: BLOCK_SIZE];
                end
            end
        end
    end

endmodule

// File: rtl/block_packer.sv
// Repacks variable-occupancy beats into dense NUM_BLOCKS-wide words, flushing a partial tail on in_last.
// Optional feature: define BLOCK_PACKER_STATS_EN to add the out_total per-frame block counter port.
module block_packer
    import block_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned NUM_BLOCKS = DEF_NUM_BLOCKS
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             in_ready,
    input  logic [NUM_BLOCKS*BLOCK_SIZE-1:0] in_data,
    input  logic                             in_valid,
    input  logic [31:0]                      in_num,
    input  logic                             in_last,
    input  logic                             ready_4_output,
    output logic [NUM_BLOCKS*BLOCK_SIZE-1:0] out_data,
    output logic                             out_valid,
    output logic [31:0]                      out_num,
    output logic                             out_last
`ifdef BLOCK_PACKER_STATS_EN
    ,
    output logic [31:0]                      out_total
`endif
);

    localparam int unsigned DEPTH = 2 * NUM_BLOCKS;
    localparam int unsigned CW    = cnt_w(NUM_BLOCKS);
    localparam logic [CW-1:0] NB  = CW'(NUM_BLOCKS);

    state_t                        state;
    state_t                        state_next;
    logic [CW-1:0]                 fill;
    logic [CW-1:0]                 fill_next;
    logic [CW-1:0]                 beat_cnt;
    logic [CW-1:0]                 pop_cnt;
    logic [CW-1:0]                 acc_cnt;
    logic [DEPTH*BLOCK_SIZE-1:0]   blocks;
    logic [DEPTH*BLOCK_SIZE-1:0]   blocks_next;
    logic                          accept;
    logic                          pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            fill   <= '0;
            blocks <= '0;
        end else begin
            state  <= state_next;
            fill   <= fill_next;
            blocks <= blocks_next;
        end
    end

    // Outputs decode from registered state only; rst forces everything low.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        beat_cnt   = NB;
        out_data   = '0;

        if (state == DRAIN) begin
            out_valid = 1'b1;
            beat_cnt  = (fill < NB) ? fill : NB;
            out_last  = (fill <= NB);
        end else begin
            in_ready  = (fill <= NB);
            out_valid = (fill >= NB);
        end

        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
            beat_cnt  = '0;
        end

        out_num = 32'(beat_cnt);
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (CW'(k) < beat_cnt) begin
                out_data[k*BLOCK_SIZE +: BLOCK_SIZE] = blocks[k*BLOCK_SIZE +: BLOCK_SIZE];
            end
        end

        accept    = in_valid && in_ready;
        pop       = out_valid && ready_4_output;
        acc_cnt   = accept ? CW'(in_num) : '0;
        pop_cnt   = pop ? beat_cnt : '0;
        fill_next = fill - pop_cnt + acc_cnt;

        if ((state == FILL) && accept && in_last) begin
            state_next = DRAIN;
        end
        if ((state == DRAIN) && pop && out_last) begin
            state_next = FILL;
            fill_next  = '0;
        end
    end

    block_insert_shift #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .NUM_BLOCKS (NUM_BLOCKS),
        .CW         (CW)
    ) u_shift (
        .blocks      (blocks),
        .fill        (fill),
        .pop_cnt     (pop_cnt),
        .acc_cnt     (acc_cnt),
        .in_data     (in_data),
        .blocks_next (blocks_next)
    );

`ifdef BLOCK_PACKER_STATS_EN
    logic [31:0] total;

    always_ff @(posedge clk) begin
        if (rst) begin
            total <= '0;
        end else if (pop) begin
            total <= out_last ? 32'd0 : total + 32'(beat_cnt);
        end
    end

    // Includes the beat currently on offer.
    assign out_total = rst ? 32'd0 : (total + (out_valid ? out_num : 32'd0));
`endif

endmodule
